// File: rtl/block_fetch_unit.sv
// Fetches one 2x2 A tile and one 2x2 B tile from a single-port RAM for the base multiplier.
// Optional define TRANSPOSE_B_EN: B tile fetched transposed (b_12 <- base_b+mat_n, b_21 <- base_b+1).
module block_fetch_unit #(
  parameter int data_w = 32,
  parameter int addr_w = 9,
  parameter int mat_n  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [addr_w-1:0] base_a,
  input  logic [addr_w-1:0] base_b,
  output logic [addr_w-1:0] ram_addr,
  input  logic [data_w-1:0] ram_r_data,
  output logic [data_w-1:0] a_11,
  output logic [data_w-1:0] a_12,
  output logic [data_w-1:0] a_21,
  output logic [data_w-1:0] a_22,
  output logic [data_w-1:0] b_11,
  output logic [data_w-1:0] b_12,
  output logic [data_w-1:0] b_21,
  output logic [data_w-1:0] b_22,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam logic [addr_w-1:0] RowStride = addr_w'(mat_n);
  localparam logic [addr_w:0]   LastAddr  = {1'b0, {addr_w{1'b1}}};
  localparam logic [addr_w:0]   TileSpan  = (addr_w+1)'(mat_n + 1);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [2:0]        capIdx_q;
  logic              capValid_q;
  logic [addr_w-1:0] baseA_q;
  logic [addr_w-1:0] baseB_q;
  logic [addr_w-1:0] ramAddr_q;
  logic [data_w-1:0] tile_q [8];
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              startLegal;

  // Tile slot order: a11 a12 a21 a22 b11 b12 b21 b22; idx[2] selects the B matrix.
  function automatic logic [addr_w-1:0] tileAddr(input logic [2:0]        idx,
                                                 input logic [addr_w-1:0] baseA,
                                                 input logic [addr_w-1:0] baseB);
    logic [1:0]        pos;
    logic [addr_w-1:0] off;
    pos = idx[1:0];
`ifdef TRANSPOSE_B_EN
    if (idx[2] && (pos == 2'd1 || pos == 2'd2)) pos = ~pos;
`endif
    case (pos)
      2'd0:    off = '0;
      2'd1:    off = addr_w'(1);
      2'd2:    off = RowStride;
      default: off = RowStride + addr_w'(1);
    endcase
    return (idx[2] ? baseB : baseA) + off;
  endfunction

  // Extra bit of headroom so base+mat_n+1 cannot wrap before the comparison.
  assign startLegal = (({1'b0, base_a} + TileSpan) <= LastAddr) &&
                      (({1'b0, base_b} + TileSpan) <= LastAddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      capIdx_q   <= '0;
      capValid_q <= 1'b0;
      baseA_q    <= '0;
      baseB_q    <= '0;
      ramAddr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 8; i++) tile_q[i] <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      capValid_q <= 1'b0;
      // Read data lags the address by one cycle, so capture uses the previous index.
      if (capValid_q) tile_q[capIdx_q] <= ram_r_data;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (startLegal) begin
              baseA_q   <= base_a;
              baseB_q   <= base_b;
              ramAddr_q <= base_a;
              idx_q     <= '0;
              busy_q    <= 1'b1;
              state_q   <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          capIdx_q   <= idx_q;
          capValid_q <= 1'b1;
          if (idx_q == 3'd7) begin
            state_q <= DRAIN;
          end else begin
            idx_q     <= idx_q + 3'd1;
            ramAddr_q <= tileAddr(idx_q + 3'd1, baseA_q, baseB_q);
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ram_addr = ramAddr_q;
  assign a_11     = tile_q[0];
  assign a_12     = tile_q[1];
  assign a_21     = tile_q[2];
  assign a_22     = tile_q[3];
  assign b_11     = tile_q[4];
  assign b_12     = tile_q[5];
  assign b_21     = tile_q[6];
  assign b_22     = tile_q[7];
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_block_fetch_unit.sv
// Scoreboard bench for block_fetch_unit: expected tiles queued at start, compared on done.
// Honours TRANSPOSE_B_EN when the design is built with it.
module tb_block_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  base_a;
  logic [8:0]  base_b;
  logic [8:0]  ram_addr;
  logic [31:0] ram_r_data;
  logic [31:0] a_11, a_12, a_21, a_22;
  logic [31:0] b_11, b_12, b_21, b_22;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0]  mem [512];
  logic [255:0] sb [$];
  logic [255:0] monExp;
  int           checks = 0;
  int           errors = 0;

  block_fetch_unit #(.data_w(32), .addr_w(9), .mat_n(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_a(base_a), .base_b(base_b),
    .ram_addr(ram_addr), .ram_r_data(ram_r_data),
    .a_11(a_11), .a_12(a_12), .a_21(a_21), .a_22(a_22),
    .b_11(b_11), .b_12(b_12), .b_21(b_21), .b_22(b_22),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 512; i++) mem[i] = 32'(i + 100);
  always @(posedge clk) ram_r_data <= mem[ram_addr];

  // Offsets of tile element k (a11,a12,a21,a22,b11,b12,b21,b22) from its base, row stride 4.
  function automatic int expOffset(input int k);
    int pos;
    pos = k % 4;
`ifdef TRANSPOSE_B_EN
    if (k >= 4 && pos == 1) pos = 2;
    else if (k >= 4 && pos == 2) pos = 1;
`endif
    case (pos)
      0:       return 0;
      1:       return 1;
      2:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int expAddr(input int ba, input int bb, input int k);
    return (k < 4 ? ba : bb) + expOffset(k);
  endfunction

  function automatic logic [255:0] expTile(input int ba, input int bb);
    logic [255:0] t;
    t = '0;
    for (int k = 0; k < 8; k++) t[255-32*k -: 32] = 32'(expAddr(ba, bb, k) + 100);
    return t;
  endfunction

  function automatic logic [255:0] dutTile();
    return {a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued tile.
  always begin
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done t=%0t got=1 exp=0", $time);
      end else begin
        monExp = sb.pop_front();
        if (dutTile() !== monExp) begin
          errors++;
          $display("[TB] FAIL tile got=%h exp=%h", dutTile(), monExp);
        end
      end
    end
  end

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1; start = 1'b0; base_a = '0; base_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b exp=000", {busy, done, err});
    end
    checks++;
    if (ram_addr !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_addr got=%0d exp=0", ram_addr);
    end
    checks++;
    if (dutTile() !== 256'd0) begin
      errors++; $display("[TB] FAIL reset_tile got=%h exp=0", dutTile());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int ea;
    $display("[TB] test_basic");
    @(negedge clk);
    base_a = 9'd0; base_b = 9'd16; start = 1'b1;
    sb.push_back(expTile(0, 16));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({busy, done, err} !== {c <= 9, c == 10, 1'b0}) begin
        errors++;
        $display("[TB] FAIL basic_timing cycle=%0d got=%b exp=%b", c, {busy, done, err},
                 {c <= 9, c == 10, 1'b0});
      end
      if (c <= 8) begin
        ea = expAddr(0, 16, c - 1);
        checks++;
        if (ram_addr !== 9'(ea)) begin
          errors++; $display("[TB] FAIL basic_addr cycle=%0d got=%0d exp=%0d", c, ram_addr, ea);
        end
      end
    end
  endtask

  task automatic test_range();
    $display("[TB] test_range");
    @(negedge clk);
    base_a = 9'd506; base_b = 9'd0; start = 1'b1;
    sb.push_back(expTile(506, 0));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({busy, done, err} !== {c <= 9, c == 10, 1'b0}) begin
        errors++;
        $display("[TB] FAIL edge_timing cycle=%0d got=%b exp=%b", c, {busy, done, err},
                 {c <= 9, c == 10, 1'b0});
      end
    end
    checks++;
    if (a_22 !== 32'd611) begin
      errors++; $display("[TB] FAIL edge_a22 got=%0d exp=611", a_22);
    end
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      base_a = (t == 0) ? 9'd507 : 9'd0;
      base_b = (t == 0) ? 9'd0 : 9'd510;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        checks++;
        if ({busy, done, err} !== {1'b0, 1'b0, c == 1}) begin
          errors++;
          $display("[TB] FAIL reject%0d_flags cycle=%0d got=%b exp=%b", t, c,
                   {busy, done, err}, {1'b0, 1'b0, c == 1});
        end
        checks++;
        if (dutTile() !== expTile(506, 0)) begin
          errors++; $display("[TB] FAIL reject%0d_tile got=%h exp=%h", t, dutTile(), expTile(506, 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic bExp;
    $display("[TB] test_back_to_back");
    @(negedge clk);
    base_a = 9'd0; base_b = 9'd16; start = 1'b1;
    sb.push_back(expTile(0, 16));
    sb.push_back(expTile(0, 16));
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) start = 1'b0;
      bExp = (c >= 1 && c <= 9) || (c >= 12 && c <= 20);
      checks++;
      if ({busy, done} !== {bExp, (c == 10) || (c == 21)}) begin
        errors++;
        $display("[TB] FAIL b2b_timing cycle=%0d got=%b exp=%b", c, {busy, done},
                 {bExp, (c == 10) || (c == 21)});
      end
    end
  endtask

  task automatic test_midreset();
    $display("[TB] test_midreset");
    @(negedge clk);
    base_a = 9'd0; base_b = 9'd16; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000 || ram_addr !== 9'd0 || dutTile() !== 256'd0) begin
      errors++;
      $display("[TB] FAIL midreset_zero got=%b/%0d/%h exp=000/0/0", {busy, done, err}, ram_addr, dutTile());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("[TB] FAIL midreset_quiet cycle=%0d got=%b exp=00", c, {busy, done});
      end
    end
    @(negedge clk);
    base_a = 9'd8; base_b = 9'd40; start = 1'b1;
    sb.push_back(expTile(8, 40));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      checks++;
      if ({busy, done} !== {c <= 9, c == 10}) begin
        errors++;
        $display("[TB] FAIL after_reset_timing cycle=%0d got=%b exp=%b", c, {busy, done}, {c <= 9, c == 10});
      end
    end
  endtask

  task automatic test_base_change();
    $display("[TB] test_base_change");
    @(negedge clk);
    base_a = 9'd0; base_b = 9'd16; start = 1'b1;
    sb.push_back(expTile(0, 16));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 3) begin base_a = 9'd32; base_b = 9'd48; end
      checks++;
      if ({busy, done} !== {c <= 9, c == 10}) begin
        errors++;
        $display("[TB] FAIL base_change_timing cycle=%0d got=%b exp=%b", c, {busy, done}, {c <= 9, c == 10});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_midreset();
    test_base_change();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL pending_tiles got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
